// File: rtl/spike_rate_decoder_if.sv
// Result handshake bundle of the spike rate decoder: packed per-channel
// counts with a valid/ready pair.
interface spike_rate_decoder_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 8
);
  logic [NUM_CH*CNT_W-1:0] rate_out;
  logic                    rate_valid;
  logic                    rate_ready;

  modport master (output rate_out, output rate_valid, input rate_ready);
  modport slave  (input rate_out, input rate_valid, output rate_ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// Per-channel spike rate decoder over a programmable window of enabled cycles.
// Define SPIKE_RATE_DECODER_SAT_EN for saturating counts (default wraps).
module spike_rate_decoder #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WIN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] spike_in,
  input  logic [WIN_W-1:0]  window_len,
  output logic              overrun,
  spike_rate_decoder_if.master rate_if
);

  typedef enum logic {ST_START, ST_COUNT} state_t;

  state_t                  state_q, state_d;
  logic [WIN_W-1:0]        remaining_q, remaining_d;
  logic [NUM_CH*CNT_W-1:0] count_q, count_d;
  logic [NUM_CH*CNT_W-1:0] rate_q, rate_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    win_end;
  logic                    load;

  function automatic logic [CNT_W-1:0] add_spike(input logic [CNT_W-1:0] c,
                                                 input logic s);
`ifdef SPIKE_RATE_DECODER_SAT_EN
    if (s && (c == '1)) return c;
    return c + CNT_W'(s);
`else
    return c + CNT_W'(s);
`endif
  endfunction

  // remaining holds the cycles still to come after the current one; the
  // window closes on the COUNT cycle that takes it from 1 to 0, giving L cycles.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    win_end     = 1'b0;
    if (enable) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count_d[i*CNT_W +: CNT_W] = add_spike(
          (state_q == ST_START) ? '0 : count_q[i*CNT_W +: CNT_W], spike_in[i]);
      end
      case (state_q)
        ST_START: begin
          remaining_d = window_len - WIN_W'(1);
          if (window_len == WIN_W'(1)) win_end = 1'b1;
          else                         state_d = ST_COUNT;
        end
        ST_COUNT: begin
          remaining_d = remaining_q - WIN_W'(1);
          if (remaining_q == WIN_W'(1)) begin
            win_end = 1'b1;
            state_d = ST_START;
          end
        end
        default: state_d = ST_START;
      endcase
    end
  end

  always_comb begin
    load      = win_end && (!valid_q || rate_if.rate_ready);
    rate_d    = load ? count_d : rate_q;
    valid_d   = valid_q;
    if (load)                              valid_d = 1'b1;
    else if (valid_q && rate_if.rate_ready) valid_d = 1'b0;
    overrun_d = overrun_q | (win_end & ~load);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_START;
      remaining_q <= '0;
      count_q     <= '0;
      rate_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      rate_q      <= rate_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rate_if.rate_out   = rate_q;
  assign rate_if.rate_valid = valid_q;
  assign overrun            = overrun_q;

endmodule
